maxnet_controller: RTL and testbench
====================================

// Module: maxnet_controller
// PURPOSE
//  Sequencer for the 4-neuron competitive (winner-take-all) datapath. On start it:
//   - loads X1..X4 into the datapath input registers;
//   - runs the first pass from the initial values;
//   - iterates the processing units until the datapath decoder raises complete,
//     or until MAX_ITER update passes have run;
//   - captures the winning input into the result register and reports done.
//  Sits between the top-level handshake and the datapath control pins
//  (sel, en0..en3, complete).
// PARAMETERS
//  MAX_ITER  15  maximum number of A-register updates before forced finish (>=1)
//  CNT_W     4   width of iteration counter; must satisfy 2**CNT_W > MAX_ITER
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous reset, active-low (0 = reset, sampled on clk)
//  start       in   1      request a run; sampled only in IDLE
//  complete    in   1      datapath decoder: single nonzero neuron remains
//  sel         out  1      datapath mux select: 1 = initial X values, 0 = fed-back A values
//  en0         out  1      load X input register block
//  en1         out  1      processing-unit internal register enable
//  en2         out  1      A register block enable
//  en3         out  1      final result register enable
//  busy        out  1      run in progress
//  done        out  1      run finished; result valid
//  timeout     out  1      last run ended by MAX_ITER, not by complete
//  iter_count  out  CNT_W  number of A updates performed in current/last run
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state=IDLE; sel, en0..en3, busy, done, timeout = 0;
//  iter_count = 0. Reset overrides any state, including mid-run.
//  All control outputs are Moore, decoded from the registered state. No combinational
//  path from inputs to outputs.
//  States, per-state outputs and transitions:
//   IDLE     all outputs 0.                  start==1 -> LOAD (clear iter_count, timeout).
//   LOAD     en0=1, busy=1.                  -> FIRST.
//   FIRST    sel=1, en1=1, busy=1.           -> UPDATE.
//   UPDATE   en2=1, busy=1; iter_count+=1.   -> CHECK.
//   CHECK    busy=1; samples complete (valid one cycle after en2).
//            complete==1                     -> CAPTURE.
//            complete==0, iter_count==MAX_ITER -> CAPTURE, set timeout.
//            otherwise                       -> ITER.
//   ITER     sel=0, en1=1, busy=1.           -> UPDATE.
//   CAPTURE  en3=1, busy=1.                  -> DONE.
//   DONE     done=1, busy=0.                 held until start==0, then -> IDLE.
//  Latency:
//   - start sampled at edge N -> done first high in cycle N+6 when complete on first CHECK.
//   - Each extra iteration adds 3 cycles (ITER, UPDATE, CHECK).
//   - Worst case: N+6+3*(MAX_ITER-1).
//  Timeout flag and iter_count hold their values through DONE and IDLE until the next
//  accepted start.
//  Boundary conditions:
//   - start outside IDLE is ignored.
//   - start held high through DONE does not retrigger; a new run needs start low, then high.
//   - complete outside CHECK is ignored.
//   - complete==1 and iter_count==MAX_ITER in the same CHECK -> normal finish, timeout=0.
//   - iter_count never exceeds MAX_ITER and never wraps.
//   - Exactly one of en0..en3 is high in any cycle, or none.
//   - Unused or illegal state encodings go to IDLE on the next clk.
// STRUCTURE
//  Shared package maxnet_pkg: state enum/localparams (IDLE, LOAD, FIRST, UPDATE,
//  CHECK, ITER, CAPTURE, DONE; 3-bit encoding) and default MAX_ITER.
//  One sub-module: iter_counter (clear, inc, saturating at MAX_ITER, outputs count
//  and at_max). FSM next-state logic and output decode live in this module.
// TESTING
//  1. rst=0 for 2 cycles mid-ITER -> next cycle all outputs 0, iter_count=0, state IDLE.
//  2. start pulse, complete=1 at first CHECK -> en0 @N+1, sel&en1 @N+2, en2 @N+3,
//     en3 @N+5, done @N+6, iter_count=1, timeout=0.
//  3. complete=0 for 2 CHECKs, 1 on the 3rd -> ITER (sel=0) twice, done at N+12,
//     iter_count=3, timeout=0.
//  4. complete held 0, MAX_ITER=15 -> done at N+48, iter_count=15, timeout=1;
//     next start clears timeout.
//  5. start held high through DONE -> done stays 1 and no new LOAD;
//     start low then high -> new run begins.
//  6. Random start/complete toggling over 10k cycles -> assert en0..en3 one-hot-or-zero,
//     done&busy never both 1, iter_count<=MAX_ITER.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared definitions for the MAXNET winner-take-all sequencer.
package maxnet_pkg;

  localparam int unsigned MAX_ITER_DEFAULT = 15;
  localparam int unsigned CNT_W_DEFAULT    = 4;

  typedef logic [2:0] state_t;

  // Legacy-compatible 3-bit state encoding; all eight codes are assigned.
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LOAD    = 3'd1;
  localparam state_t S_FIRST   = 3'd2;
  localparam state_t S_UPDATE  = 3'd3;
  localparam state_t S_CHECK   = 3'd4;
  localparam state_t S_ITER    = 3'd5;
  localparam state_t S_CAPTURE = 3'd6;
  localparam state_t S_DONE    = 3'd7;

endpackage

// File: rtl/maxnet_controller_iter_counter.sv
// Saturating iteration counter: counts A-register updates up to MAX_ITER.
module iter_counter
  import maxnet_pkg::*;
#(
  parameter int unsigned MAX_ITER = MAX_ITER_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_ITER);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over increment; increment stops at MAX_VAL so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX_VAL);

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer for the 4-neuron MAXNET datapath: load, first pass, iterate
// until complete or MAX_ITER updates, capture the winner, report done.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int unsigned MAX_ITER = MAX_ITER_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             complete,
  output logic             sel,
  output logic             en0,
  output logic             en1,
  output logic             en2,
  output logic             en3,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_count
);

  state_t state_q;
  state_t state_d;
  logic   timeout_q;
  logic   timeout_d;
  logic   cnt_clear;
  logic   cnt_inc;
  logic   cnt_at_max;

  assign cnt_clear = (state_q == S_IDLE) && start;
  assign cnt_inc   = (state_q == S_UPDATE);

  iter_counter #(
    .MAX_ITER (MAX_ITER),
    .CNT_W    (CNT_W)
  ) u_iter_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .count  (iter_count),
    .at_max (cnt_at_max)
  );

  // Next-state and timeout-flag logic; complete is only looked at in CHECK.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          timeout_d = 1'b0;
        end
      end
      S_LOAD:   state_d = S_FIRST;
      S_FIRST:  state_d = S_UPDATE;
      S_UPDATE: state_d = S_CHECK;
      S_CHECK: begin
        if (complete) begin
          state_d = S_CAPTURE;
        end else if (cnt_at_max) begin
          state_d   = S_CAPTURE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER:    state_d = S_UPDATE;
      S_CAPTURE: state_d = S_DONE;
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // State and timeout registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    sel  = 1'b0;
    en0  = 1'b0;
    en1  = 1'b0;
    en2  = 1'b0;
    en3  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_LOAD:    begin en0 = 1'b1; busy = 1'b1; end
      S_FIRST:   begin sel = 1'b1; en1 = 1'b1; busy = 1'b1; end
      S_UPDATE:  begin en2 = 1'b1; busy = 1'b1; end
      S_CHECK:   begin busy = 1'b1; end
      S_ITER:    begin en1 = 1'b1; busy = 1'b1; end
      S_CAPTURE: begin en3 = 1'b1; busy = 1'b1; end
      S_DONE:    begin done = 1'b1; end
      default:   begin end
    endcase
  end

  assign timeout = timeout_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller (MAX_ITER=15, CNT_W=4).
module tb_maxnet_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       complete;
  logic       sel, en0, en1, en2, en3, busy, done, timeout;
  logic [3:0] iter_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  maxnet_controller #(
    .MAX_ITER (15),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .complete   (complete),
    .sel        (sel),
    .en0        (en0),
    .en1        (en1),
    .en2        (en2),
    .en3        (en3),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .iter_count (iter_count)
  );

  // Control-output patterns {sel,en0,en1,en2,en3,busy,done,timeout}
  localparam logic [7:0] O_IDLE    = 8'b0000_0000;
  localparam logic [7:0] O_LOAD    = 8'b0100_0100;
  localparam logic [7:0] O_FIRST   = 8'b1010_0100;
  localparam logic [7:0] O_UPDATE  = 8'b0001_0100;
  localparam logic [7:0] O_CHECK   = 8'b0000_0100;
  localparam logic [7:0] O_ITER    = 8'b0010_0100;
  localparam logic [7:0] O_CAPTURE = 8'b0000_1100;
  localparam logic [7:0] O_DONE    = 8'b0000_0010;

  typedef struct {
    string      name;
    logic       start;
    logic       complete;
    logic [7:0] ctl;
    logic [3:0] iter;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic s, logic c, logic [7:0] o, logic [3:0] it);
    vec_t v;
    v.name = n; v.start = s; v.complete = c; v.ctl = o; v.iter = it;
    return v;
  endfunction

  function automatic logic [11:0] snap();
    return {sel, en0, en1, en2, en3, busy, done, timeout, iter_count};
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b ({sel,en0..en3,busy,done,timeout,iter})", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until done is seen; returns number of edges taken, or limit on expiry.
  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      step();
      cycles++;
    end
  endtask

  int cyc;
  int k;

  initial begin
    rst = 1'b0; start = 1'b0; complete = 1'b0;
    step(); step();
    chk("reset_state", snap(), 12'b0);
    rst = 1'b1;
    step();
    chk("idle_after_reset", snap(), 12'b0);

    // Single-pass run with complete toggled outside CHECK, then a 3-check run.
    vecs.push_back(mk("t2_load",     1, 0, O_LOAD,    4'd0));
    vecs.push_back(mk("t2_first",    0, 1, O_FIRST,   4'd0));
    vecs.push_back(mk("t2_update",   0, 1, O_UPDATE,  4'd0));
    vecs.push_back(mk("t2_check",    0, 0, O_CHECK,   4'd1));
    vecs.push_back(mk("t2_capture",  0, 1, O_CAPTURE, 4'd1));
    vecs.push_back(mk("t2_done",     0, 0, O_DONE,    4'd1));
    vecs.push_back(mk("t2_idle",     0, 0, O_IDLE,    4'd1));
    vecs.push_back(mk("t2_idle_cpl", 0, 1, O_IDLE,    4'd1));
    vecs.push_back(mk("t3_load",     1, 0, O_LOAD,    4'd0));
    vecs.push_back(mk("t3_first",    0, 0, O_FIRST,   4'd0));
    vecs.push_back(mk("t3_update1",  0, 0, O_UPDATE,  4'd0));
    vecs.push_back(mk("t3_check1",   0, 0, O_CHECK,   4'd1));
    vecs.push_back(mk("t3_iter1",    0, 0, O_ITER,    4'd1));
    vecs.push_back(mk("t3_update2",  1, 0, O_UPDATE,  4'd1));
    vecs.push_back(mk("t3_check2",   0, 0, O_CHECK,   4'd2));
    vecs.push_back(mk("t3_iter2",    0, 0, O_ITER,    4'd2));
    vecs.push_back(mk("t3_update3",  0, 0, O_UPDATE,  4'd2));
    vecs.push_back(mk("t3_check3",   0, 0, O_CHECK,   4'd3));
    vecs.push_back(mk("t3_capture",  0, 1, O_CAPTURE, 4'd3));
    vecs.push_back(mk("t3_done",     0, 0, O_DONE,    4'd3));
    vecs.push_back(mk("t3_idle",     0, 0, O_IDLE,    4'd3));

    foreach (vecs[i]) begin
      start    = vecs[i].start;
      complete = vecs[i].complete;
      step();
      chk(vecs[i].name, snap(), {vecs[i].ctl, vecs[i].iter});
    end

    // Forced finish after MAX_ITER updates: done 48 edges after start.
    start = 1'b1; complete = 1'b0;
    step();
    start = 1'b0;
    wait_done(200, cyc);
    chk_int("timeout_latency", cyc + 1, 48);
    chk("timeout_done", snap(), {O_DONE | 8'b1, 4'd15});
    step();
    chk("timeout_held_idle", snap(), {O_IDLE | 8'b1, 4'd15});
    start = 1'b1;
    step();
    chk("timeout_cleared", snap(), {O_LOAD, 4'd0});
    start = 1'b0; complete = 1'b1;
    wait_done(50, cyc);
    chk_int("fast_latency", cyc + 1, 6);
    chk("fast_done", snap(), {O_DONE, 4'd1});
    complete = 1'b0;
    step();

    // complete arrives in the same CHECK that reaches MAX_ITER: normal finish.
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!(busy && !sel && !en0 && !en1 && !en2 && !en3 && iter_count == 4'd15) && k < 80) begin
      step();
      k++;
    end
    chk_int("reach_last_check", k < 80 ? 1 : 0, 1);
    complete = 1'b1;
    step();
    chk("last_check_capture", snap(), {O_CAPTURE, 4'd15});
    complete = 1'b0;
    step();
    chk("last_check_done", snap(), {O_DONE, 4'd15});
    step();

    // start held high through DONE must not retrigger.
    start = 1'b1; complete = 1'b1;
    wait_done(50, cyc);
    chk_int("held_latency", cyc, 6);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_start_done", snap(), {O_DONE, 4'd1});
    end
    start = 1'b0;
    step();
    chk("held_release_idle", snap(), {O_IDLE, 4'd1});
    start = 1'b1;
    step();
    chk("held_restart_load", snap(), {O_LOAD, 4'd0});
    start = 1'b0;
    wait_done(50, cyc);
    chk_int("held_restart_done", cyc, 5);
    step();

    // Reset asserted for two cycles mid-ITER.
    start = 1'b1; complete = 1'b0;
    step();
    start = 1'b0;
    k = 0;
    while (!(en1 && !sel) && k < 20) begin
      step();
      k++;
    end
    chk("reach_iter", snap(), {O_ITER, 4'd1});
    rst = 1'b0;
    step();
    chk("midrun_reset1", snap(), 12'b0);
    step();
    chk("midrun_reset2", snap(), 12'b0);
    rst = 1'b1;
    step();
    chk("post_reset_idle", snap(), 12'b0);

    // Random start/complete: structural invariants every cycle.
    for (int i = 0; i < 10000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      complete = ($urandom_range(0, 7) == 0);
      step();
      n_cmp++;
      if (!$onehot0({en0, en1, en2, en3}) || (done && busy) || iter_count > 4'd15) begin
        n_bad++;
        $display("FAIL random_invariant cycle %0d: got en=%b done=%b busy=%b iter=%0d required onehot0, !(done&busy), iter<=15",
                 i, {en0, en1, en2, en3}, done, busy, iter_count);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
